// File: rtl/flat_serializer.sv
// flat_serializer: captures a flattened ROWS x COLS array word and emits its
// elements one per transfer in row-major order, (0,0) taken from the MSBs.
`default_nettype none

module flat_serializer #(
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*COLS*W-1:0]   in_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [7:0]               out_row,
  output logic [7:0]               out_col,
  output logic                     out_last,
  output logic [15:0]              frame_count
);

  localparam int         N        = ROWS * COLS;
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [N*W-1:0]  cap;
  logic [15:0]     idx;
  logic [7:0]      nxt_row;
  logic [7:0]      nxt_col;
  logic            nxt_last;
  logic            accept;
  logic            xfer;

  // Element k sits at the k-th W-bit slot counting down from the MSB end.
  function automatic logic [W-1:0] elem(input logic [N*W-1:0] v, input logic [15:0] k);
    return v[(N - 1 - int'(k)) * W +: W];
  endfunction

  always_comb begin
    in_ready = (state == IDLE) || (out_last && out_ready);
    nxt_col  = (out_col == LAST_COL) ? 8'd0 : out_col + 8'd1;
    nxt_row  = (out_col == LAST_COL) ? out_row + 8'd1 : out_row;
    nxt_last = (nxt_row == LAST_ROW) && (nxt_col == LAST_COL);
  end

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cap         <= '0;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (xfer && out_last) begin
        frame_count <= frame_count + 16'd1;
      end
      // In SEND an accept can only coincide with the final transfer.
      if (accept) begin
        state     <= SEND;
        cap       <= in_flat;
        idx       <= '0;
        out_valid <= 1'b1;
        out_data  <= elem(in_flat, 16'd0);
        out_row   <= '0;
        out_col   <= '0;
        out_last  <= (N == 1);
      end else if (xfer) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end else begin
          idx      <= idx + 16'd1;
          out_data <= elem(cap, idx + 16'd1);
          out_row  <= nxt_row;
          out_col  <= nxt_col;
          out_last <= nxt_last;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flat_serializer.sv
// Directed bench for flat_serializer: queue scoreboard of expected elements plus
// directed checks for backpressure, back-to-back, mid-frame reset and counter wrap.
`default_nettype none

module tb_flat_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [47:0] in_flat = '0;
  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_data, out_row, out_col;
  logic [15:0] frame_count;

  logic        rst2 = 1'b1;
  logic        in_valid2 = 1'b0;
  logic        out_ready2 = 1'b0;
  logic [7:0]  in_flat2 = '0;
  logic        in_ready2, out_valid2, out_last2;
  logic [7:0]  out_data2, out_row2, out_col2;
  logic [15:0] frame_count2;

  flat_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flat(in_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .frame_count(frame_count)
  );

  flat_serializer #(.ROWS(1), .COLS(1), .W(8)) dut_wrap (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_flat(in_flat2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_row(out_row2),
    .out_col(out_col2), .out_last(out_last2), .frame_count(frame_count2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] c;
    logic       l;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_fc = '0;
  logic        held = 1'b0;
  exp_t        prev;

  // Scoreboard monitor: inputs change at posedge+1, so negedge sees a stable cycle.
  always @(negedge clk) begin
    exp_t        cur;
    logic        exp_ir;
    logic [47:0] w;
    if (rst) begin
      q.delete();
      exp_fc = '0;
      held   = 1'b0;
    end else begin
      cur    = {out_data, out_row, out_col, out_last};
      exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("mon_valid", out_valid, q.size() != 0);
      chk("mon_frame_count", frame_count, exp_fc);
      chk("mon_in_ready", in_ready, exp_ir);
      if (held) chk("mon_hold_stable", cur, prev);
      if (out_valid && q.size() != 0) begin
        chk("mon_element", cur, q[0]);
        if (out_ready) begin
          if (q[0].l) exp_fc = exp_fc + 16'd1;
          void'(q.pop_front());
        end
      end
      held = out_valid && !out_ready;
      prev = cur;
      if (in_valid && exp_ir) begin
        w = in_flat;
        for (int k = 0; k < 6; k++) begin
          exp_t e;
          e.d = w[(5 - k) * 8 +: 8];
          e.r = 8'(k / 3);
          e.c = 8'(k % 3);
          e.l = (k == 5);
          q.push_back(e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (out_valid && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_timeout", n < 50, 1'b1);
  endtask

  initial begin
    int lastcnt;
    int n;

    repeat (2) cyc();
    rst  = 1'b0;
    rst2 = 1'b0;

    // Reset state and idle input for 20 cycles
    for (int i = 0; i < 20; i++) begin
      chk("idle_outputs",
          {in_ready, out_valid, out_data, out_row, out_col, out_last, frame_count},
          {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000});
      cyc();
    end

    // Basic frame
    in_flat   = 48'h010203040506;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("basic_first", {out_valid, out_data, out_row, out_col}, {1'b1, 8'h01, 8'h00, 8'h00});
    wait_idle();
    chk("basic_frame_count", frame_count, 16'd1);

    // Backpressure while (0,1) is shown
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    repeat (3) begin
      chk("bp_hold", {out_valid, out_data, out_row, out_col}, {1'b1, 8'h02, 8'h00, 8'h01});
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_resume", {out_data, out_row, out_col}, {8'h03, 8'h00, 8'h02});
    wait_idle();
    chk("bp_frame_count", frame_count, 16'd2);

    // Back-to-back frames
    in_valid = 1'b1;
    cyc();
    in_flat = 48'hA1A2A3A4A5A6;
    repeat (5) begin
      chk("b2b_not_ready", in_ready, 1'b0);
      cyc();
    end
    chk("b2b_ready_on_last", {in_ready, out_data, out_last}, {1'b1, 8'h06, 1'b1});
    cyc();
    in_valid = 1'b0;
    chk("b2b_no_bubble", {out_valid, out_data, out_row, out_col}, {1'b1, 8'hA1, 8'h00, 8'h00});
    wait_idle();
    chk("b2b_frame_count", frame_count, 16'd4);

    // Reset mid-frame at (1,0)
    in_flat  = 48'h0A0B0C0D0E0F;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_at_1_0", {out_row, out_col, out_data}, {8'h01, 8'h00, 8'h0D});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_frame",
        {in_ready, out_valid, out_data, out_row, out_col, out_last, frame_count},
        {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000});
    in_flat  = 48'h112233445566;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("rst_new_frame", {out_valid, out_data, out_row, out_col}, {1'b1, 8'h11, 8'h00, 8'h00});
    wait_idle();
    chk("rst_new_frame_count", frame_count, 16'd1);

    // Frame counter wrap on a 1x1 instance, one frame per cycle
    in_flat2   = 8'h5A;
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    lastcnt    = 0;
    n          = 0;
    while (lastcnt < 65536 && n < 70000) begin
      @(negedge clk);
      n++;
      if (out_valid2 && out_ready2 && out_last2) begin
        if (lastcnt == 65535) chk("wrap_before", frame_count2, 16'hFFFF);
        lastcnt++;
        if (lastcnt == 65536) in_valid2 = 1'b0;
      end
    end
    chk("wrap_last_pulses", lastcnt, 65536);
    cyc();
    chk("wrap_frame_count", {out_valid2, frame_count2}, {1'b0, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flat_serializer.md
FLAT_SERIALIZER -- requirements
Module: flat_serializer

Interface
REQ-001 Parameter ROWS, default 2: number of rows in the packed array word.
REQ-002 Parameter COLS, default 3: number of columns in the packed array word.
REQ-003 Parameter W, default 8: element width in bits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  upstream offers in_flat.
REQ-007 in_ready  output  1  block accepts in_flat this cycle.
REQ-008 in_flat  input  ROWS*COLS*W (48)  flattened ROWS x COLS array from the upstream array stage.
REQ-009 out_valid  output  1  out_data/out_row/out_col/out_last are valid.
REQ-010 out_ready  input  1  downstream accepts the current element.
REQ-011 out_data  output  W  current element.
REQ-012 out_row  output  8  row index of the current element.
REQ-013 out_col  output  8  column index of the current element.
REQ-014 out_last  output  1  current element is the final element, (ROWS-1, COLS-1).
REQ-015 frame_count  output  16  number of frames fully emitted.

Function
REQ-016 Element k = r*COLS + c SHALL occupy in_flat[(ROWS*COLS-k)*W-1 : (ROWS*COLS-k-1)*W], so element (0,0) is the MSBs (bits 47:40 at defaults).
REQ-017 Input handshake: a word is accepted on any edge where in_valid && in_ready; the whole word is captured into an internal register.
REQ-018 Output handshake: an element transfers on any edge where out_valid && out_ready.
REQ-019 The FSM SHALL have two states, IDLE and SEND.
REQ-020 IDLE: in_ready=1 and out_valid=0; an accepted word moves the FSM to SEND with the element index at 0.
REQ-021 SEND: out_valid=1, and the element index is shown on out_row/out_col in row-major order: (0,0),(0,1),...,(0,COLS-1),(1,0),...
REQ-022 The first out_valid SHALL occur on the cycle after input acceptance (latency 1).
REQ-023 While out_valid && !out_ready, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-024 A transfer that is not the last SHALL advance the index by one; the column wraps to 0 and the row increments at COLS-1.
REQ-025 In SEND, in_ready = out_last && out_ready, so the block accepts the next word in the same cycle as the final transfer.
REQ-026 Final transfer with a simultaneous input acceptance: stay in SEND, index to 0, and the new word is presented the next cycle (no bubble).
REQ-027 Final transfer without an input acceptance: return to IDLE.
REQ-028 frame_count SHALL increment by 1 on each final-element transfer and wrap from 0xFFFF to 0x0000.
REQ-029 out_row and out_col are zero-extended to 8 bits; ROWS and COLS SHALL each be at most 256.
REQ-030 In SEND, in_valid without the final transfer has no effect; the word is not captured.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL enter IDLE with the following values:
  - index 0, capture register 0;
  - out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0;
  - frame_count=0, in_ready=1 from the following cycle.
REQ-032 Reset mid-frame SHALL abandon the frame without incrementing frame_count, and rst has priority over all handshakes in the same cycle.

Verification
REQ-033 Basic frame: in_flat=0x010203040506, out_ready=1 held -> out_data 01,02,03,04,05,06 on six consecutive cycles starting one cycle after acceptance; (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); out_last only on 06; frame_count goes 0->1.
REQ-034 Backpressure: out_ready=0 for 3 cycles while element (0,1)=0x02 is shown -> outputs held stable for those 3 cycles; sequence then resumes with 0x03; no element lost or duplicated.
REQ-035 Back-to-back: second word 0xA1A2A3A4A5A6 held valid during frame 1 -> in_ready=1 only on the 0x06 transfer cycle; 0xA1 at (0,0) presented the next cycle; frame_count=2 after 12 transfers.
REQ-036 Reset mid-frame: rst=1 while element (1,0) is shown -> next cycle out_valid=0, frame_count unchanged (0), in_ready=1; a new word then emits from (0,0).
REQ-037 Wrap: 65536 frames with out_ready=1 -> frame_count returns to 0x0000; out_last pulses exactly once per frame.
REQ-038 Idle input: in_valid=0 for 20 cycles after reset -> out_valid stays 0 and all outputs remain at reset values.
